// File: rtl/lcd_ctrl.sv
// lcd_ctrl
// --------
// Peripheral-side controller for the memory-mapped LCD output register.
// LSU writes to the LCD register are captured into a small FIFO. Each entry
// is then replayed onto an HD44780-style parallel bus: RS/DATA are set up,
// E is pulsed, and the command-execution time is waited out before the next
// entry is taken. Busy/overflow/count status is returned for LSU read-back.
//
// Optional feature macro: LCD_POWERON_INIT_EN
//   When defined, adds parameter POWERON_CYC and an INIT state. After reset
//   the controller waits POWERON_CYC cycles, then issues 8'h38, 8'h0C,
//   8'h01, 8'h06 (RS=0) before it starts draining the FIFO.
//
// Ports
//   i_clk        : clock, all state on the rising edge
//   i_rst        : asynchronous, active-low reset
//   i_lcd_word   : written value; [31]=ON, [30]=CLR_OVF, [8]=RS, [7:0]=DATA
//   i_lcd_wr     : one-cycle write strobe from the LSU
//   o_status     : [0]=busy, [1]=overflow (sticky), [4:2]=FIFO count
//   o_lcd_on     : LCD power/backlight
//   o_lcd_rs     : register select
//   o_lcd_rw     : read/write, tied to 0 (write-only bus)
//   o_lcd_en     : enable strobe
//   o_lcd_data   : data bus
//   o_dbg_state  : current FSM state encoding (0=IDLE,1=SETUP,2=PULSE,
//                  3=WAIT,4=INIT)
//
// Handshake: the LSU side has no back-pressure. A strobe on i_lcd_wr is
// always consumed in the cycle it is asserted; if it cannot be stored the
// entry is dropped and the sticky overflow flag records the loss.

module lcd_ctrl #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYC    = 4,
  parameter int EN_HIGH_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
`ifdef LCD_POWERON_INIT_EN
  ,
  parameter int POWERON_CYC  = 750000
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_wr,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic [2:0]  o_dbg_state
);

  // ---------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam int MAX_A = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
`ifdef LCD_POWERON_INIT_EN
  localparam int MAX_B = (POWERON_CYC > MAX_A) ? POWERON_CYC : MAX_A;
`else
  localparam int MAX_B = MAX_A;
`endif
  // The setup and pulse loads share the same counter, so they must fit too.
  localparam int MAX_C = (SETUP_CYC > MAX_B) ? SETUP_CYC : MAX_B;
  localparam int MAX_D = (EN_HIGH_CYC > MAX_C) ? EN_HIGH_CYC : MAX_C;
  localparam int CNT_W = (MAX_D >= 2) ? $clog2(MAX_D) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);
`ifdef LCD_POWERON_INIT_EN
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(POWERON_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3
`ifdef LCD_POWERON_INIT_EN
    ,
    ST_INIT  = 3'd4
`endif
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------
  logic [8:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          ovf_q;
  logic          on_q;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;

  assign push_req = i_lcd_wr & ~i_lcd_word[30];
  assign full     = (fifo_count == CW'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_lcd_word[8:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_q      <= 1'b0;
      on_q       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (i_lcd_wr) begin
        on_q <= i_lcd_word[31];
        if (i_lcd_word[30]) begin
          ovf_q <= 1'b0;
        end else if (full && !pop) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bus sequencer
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             long_wait;

`ifdef LCD_POWERON_INIT_EN
  logic [2:0] init_idx_q, init_idx_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction
`endif

  // Clear display and return home take far longer to execute than
  // any other instruction.
  assign long_wait = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
`ifdef LCD_POWERON_INIT_EN
      state_q    <= ST_INIT;
      cnt_q      <= LD_PWR;
      init_idx_q <= 3'd0;
`else
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
`endif
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      en_q       <= en_d;
`ifdef LCD_POWERON_INIT_EN
      init_idx_q <= init_idx_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    data_d     = data_q;
    pop        = 1'b0;
`ifdef LCD_POWERON_INIT_EN
    init_idx_d = init_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          rs_d    = fifo_mem[rd_ptr][8];
          data_d  = fifo_mem[rd_ptr][7:0];
          cnt_d   = LD_SETUP;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = LD_EN;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = long_wait ? LD_CLR : LD_CMD;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
`ifdef LCD_POWERON_INIT_EN
          // Chain straight into the next init command while any remain.
          if (init_idx_q != 3'd4) begin
            rs_d       = 1'b0;
            data_d     = init_cmd(init_idx_q[1:0]);
            init_idx_d = init_idx_q + 3'd1;
            cnt_d      = LD_SETUP;
            state_d    = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef LCD_POWERON_INIT_EN
      ST_INIT: begin
        if (cnt_q == '0) begin
          rs_d       = 1'b0;
          data_d     = init_cmd(init_idx_q[1:0]);
          init_idx_d = init_idx_q + 3'd1;
          cnt_d      = LD_SETUP;
          state_d    = ST_SETUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // E is a registered copy of "in PULSE" so the pin never glitches.
    en_d = (state_d == ST_PULSE);
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic       busy;
  logic [2:0] count_field;
  logic       unused_word;

  assign busy        = (state_q != ST_IDLE) | (fifo_count != '0);
  assign count_field = 3'(fifo_count);
  assign unused_word = ^{i_lcd_word[29:9]};

  assign o_status    = {27'd0, count_field, ovf_q, busy};
  assign o_lcd_on    = on_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_data  = data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl with SETUP_CYC=2, EN_HIGH_CYC=3, CMD_WAIT_CYC=5,
// CLR_WAIT_CYC=20, DEPTH=4, init feature off.
// Each expected E pulse is pushed into exp_q when its write is issued; a
// monitor pops on every rising E and also checks pulse width and the
// busy time that follows.

module tb_lcd_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int EN_CYC    = 3;
  localparam int CMD_WAIT  = 5;
  localparam int CLR_WAIT  = 20;

  // Clock / reset / DUT
  logic        clk;
  logic        rst_n;
  logic [31:0] lcd_word;
  logic        lcd_wr;
  logic [31:0] status;
  logic        lcd_on;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [7:0]  lcd_data;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl #(
    .DEPTH        (4),
    .SETUP_CYC    (SETUP_CYC),
    .EN_HIGH_CYC  (EN_CYC),
    .CMD_WAIT_CYC (CMD_WAIT),
    .CLR_WAIT_CYC (CLR_WAIT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_lcd_word  (lcd_word),
    .i_lcd_wr    (lcd_wr),
    .o_status    (status),
    .o_lcd_on    (lcd_on),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_data  (lcd_data),
    .o_dbg_state (dbg_state)
  );

  // Scoreboard state
  logic [8:0] exp_q[$];
  int         n_chk;
  int         n_pass;
  int         n_exp_pulses;
  int         n_pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [8:0] e);
    exp_q.push_back(e);
    n_exp_pulses++;
  endtask

  // Drives the strobe so it is captured on the next rising edge; returns
  // just after that edge.
  task automatic wr(input logic [31:0] w);
    @(negedge clk);
    lcd_word = w;
    lcd_wr   = 1'b1;
    @(posedge clk);
    #1;
    lcd_wr   = 1'b0;
    lcd_word = 32'h0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    while (status[0] && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, status[0]}, 32'd0);
  endtask

  // Monitor: pulse content, pulse width, and post-pulse busy / gap length.
  int         mon_phase;
  int         hi_cnt;
  int         low_cnt;
  int         cur_wait;
  logic       prev_en;
  logic [8:0] e_pop;

  initial begin
    mon_phase = 0;
    hi_cnt    = 0;
    low_cnt   = 0;
    cur_wait  = 0;
    prev_en   = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_phase = 0;
      hi_cnt    = 0;
      low_cnt   = 0;
      prev_en   = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        // Next pulse straight after a wait: gap = wait + idle pop edge + setup.
        if (mon_phase == 2) begin
          chk("pulse_gap", low_cnt, cur_wait + 1 + SETUP_CYC);
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL pulse_extra: got rs/data %h expected none at %0t",
                   {lcd_rs, lcd_data}, $time);
          cur_wait = CMD_WAIT;
        end else begin
          e_pop = exp_q.pop_front();
          chk("pulse_data", {23'd0, lcd_rs, lcd_data}, {23'd0, e_pop});
          cur_wait = (!e_pop[8] && (e_pop[7:0] == 8'h01 || e_pop[7:0] == 8'h02))
                     ? CLR_WAIT : CMD_WAIT;
        end
        n_pulses++;
        hi_cnt    = 1;
        mon_phase = 1;
      end else if (lcd_en) begin
        hi_cnt++;
      end else if (prev_en) begin
        chk("pulse_width", hi_cnt, EN_CYC);
        low_cnt   = status[0] ? 1 : 0;
        mon_phase = 2;
      end else if (mon_phase == 2) begin
        if (status[0]) begin
          low_cnt++;
        end else begin
          chk("busy_wait", low_cnt, cur_wait);
          mon_phase = 0;
        end
      end
      prev_en = lcd_en;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  int pulses_before;

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    n_exp_pulses = 0;
    n_pulses     = 0;
    rst_n        = 1'b0;
    lcd_wr       = 1'b0;
    lcd_word     = 32'h0;

    // Reset state
    step(3);
    chk("rst_status", status, 32'h0);
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_on_rs", {30'd0, lcd_on, lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single data write, cycle-exact
    expect_pulse(9'h141);
    wr(32'h8000_0141);                   // edge 0
    step(1);
    chk("single_on_e0", {31'd0, lcd_on}, 32'd1);
    chk("single_status_e0", status, 32'h5);
    step(1);                             // edge 1
    chk("single_rsdata_e1", {23'd0, lcd_rs, lcd_data}, 32'h141);
    chk("single_status_e1", status, 32'h1);
    step(1);                             // edge 2
    chk("single_en_e2", {31'd0, lcd_en}, 32'd0);
    step(1);                             // edge 3
    chk("single_en_e3", {31'd0, lcd_en}, 32'd1);
    step(2);                             // edge 5
    chk("single_en_e5", {31'd0, lcd_en}, 32'd1);
    step(1);                             // edge 6
    chk("single_en_e6", {31'd0, lcd_en}, 32'd0);
    chk("single_hold_e6", {23'd0, lcd_rs, lcd_data}, 32'h141);
    step(4);                             // edge 10
    chk("single_busy_e10", status, 32'h1);
    step(1);                             // edge 11
    chk("single_idle_e11", status, 32'h0);

    // Clear/home commands take the long wait; others the short one
    expect_pulse(9'h001);
    wr(32'h0000_0001);
    step(1);
    chk("clear_on_off", {31'd0, lcd_on}, 32'd0);
    wait_idle(100, "clear_idle");
    expect_pulse(9'h003);
    wr(32'h0000_0003);
    wait_idle(100, "cmd03_idle");
    expect_pulse(9'h101);
    wr(32'h0000_0101);
    wait_idle(100, "rs1_01_idle");
    expect_pulse(9'h002);
    wr(32'h0000_0002);
    wait_idle(100, "home_idle");

    // Overflow: 6 back-to-back strobes, entry 6 dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) expect_pulse(9'h100 | 9'(i));
      wr(32'h8000_0100 | 32'(i));
    end
    step(1);
    chk("ovf_status", status, 32'h13);

    // Control-only write clears overflow, enqueues nothing
    wr(32'h4000_0000);
    step(1);
    chk("clr_ovf_status", status, 32'h11);
    chk("clr_ovf_on", {31'd0, lcd_on}, 32'd0);
    wait_idle(300, "ovf_drain_idle");
    chk("ovf_drained_q", exp_q.size(), 32'd0);
    chk("ovf_pulse_count", n_pulses, n_exp_pulses);

    // Reset in the middle of an E pulse
    expect_pulse(9'h155);
    wr(32'h8000_0155);
    begin
      int n;
      n = 0;
      while (!lcd_en && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_mid_en_seen", {31'd0, lcd_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_mid_status", status, 32'h0);
    chk("rst_mid_outs", {22'd0, lcd_on, lcd_rs, lcd_data}, 32'd0);
    pulses_before = n_pulses;
    step(3);
    rst_n = 1'b1;
    step(30);
    chk("rst_no_pulse", n_pulses, pulses_before);
    chk("rst_idle_status", status, 32'h0);

    // Final scoreboard state
    chk("final_q_empty", exp_q.size(), 32'd0);
    chk("final_pulse_count", n_pulses, n_exp_pulses);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
